// File: rtl/shift_left_seq_if.sv
// Request/result bus for shift_left_seq: operand-issue side in, pack/align side out.
interface shift_left_seq_if #(
  parameter int LANE_W = 12,
  parameter int LANES  = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic [LANE_W*LANES-1:0]   in_data;
  logic [3:0]                in_amt;
  logic [LANE_W-1:0]         in_fill;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANE_W*LANES-1:0]   out_data;
  logic                      amt_clamp;
  logic                      busy;

  modport master (
    output in_valid, in_data, in_amt, in_fill, out_ready,
    input  in_ready, out_valid, out_data, amt_clamp, busy
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_fill, out_ready,
    output in_ready, out_valid, out_data, amt_clamp, busy
  );
endinterface

// File: rtl/shift_left_seq.sv
// Multi-pass lane-shift sequencer: splits a 0-15 lane shift (clamped to LANES) into <=MAX_STEP passes.
// Optional SHIFT_LEFT_SEQ_FASTPATH_EN applies the first pass combinationally in the accept cycle.
module shift_left_seq #(
  parameter int LANE_W   = 12,
  parameter int LANES    = 8,
  parameter int MAX_STEP = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  shift_left_seq_if.slave bus
);

  localparam int W = LANE_W * LANES;
  localparam logic [3:0] MAX_AMT  = 4'(LANES);
  localparam logic [3:0] STEP_LIM = 4'(MAX_STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state;
  state_t              state_next;
  logic [W-1:0]        work;
  logic [LANE_W-1:0]   fill_q;
  logic [3:0]          rem;
  logic                clamp_q;

  logic                accept;
  logic [3:0]          amt_sat;
  logic [3:0]          rem_next;
  logic [W-1:0]        core_in;
  logic [LANE_W-1:0]   core_fill;
  logic [3:0]          core_shift;
  logic [W-1:0]        core_out;
  logic                core_valid;
  logic [W-1:0]        work_load;

  assign accept  = bus.in_valid && (state == IDLE);
  assign amt_sat = (bus.in_amt > MAX_AMT) ? MAX_AMT : bus.in_amt;

  // Select what the lane shifter works on this cycle and the shift left over afterwards.
  always_comb begin
    core_in    = work;
    core_fill  = fill_q;
    core_shift = (rem > STEP_LIM) ? STEP_LIM : rem;
    rem_next   = rem - core_shift;
    work_load  = bus.in_data;
    if (accept) begin
`ifdef SHIFT_LEFT_SEQ_FASTPATH_EN
      core_in    = bus.in_data;
      core_fill  = bus.in_fill;
      core_shift = (amt_sat > STEP_LIM) ? STEP_LIM : amt_sat;
      rem_next   = amt_sat - core_shift;
      work_load  = core_out;
`else
      rem_next   = amt_sat;
`endif
    end
  end

  // Lane shifter core: result only guaranteed for shifts up to MAX_STEP.
  always_comb begin
    core_out   = (core_in << (core_shift * LANE_W))
               | ({LANES{core_fill}} & ~({W{1'b1}} << (core_shift * LANE_W)));
    core_valid = (core_shift <= STEP_LIM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (rem_next == 4'd0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        state_next = (rem_next == 4'd0) ? DONE : SHIFT;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.out_data  = (state == DONE) ? work : '0;
    bus.busy      = (state != IDLE);
    bus.amt_clamp = clamp_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work    <= '0;
      fill_q  <= '0;
      rem     <= '0;
      clamp_q <= 1'b0;
    end else begin
      clamp_q <= accept && (bus.in_amt > MAX_AMT);
      if (accept) begin
        work   <= work_load;
        fill_q <= bus.in_fill;
        rem    <= rem_next;
      end else if (state == SHIFT) begin
        work <= core_out;
        rem  <= rem_next;
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && state == SHIFT) begin
      assert (core_valid);
    end
  end
`endif

endmodule
